// File: rtl/seq_pkg.sv
// Shared definitions for the 1101 serial link (transmitter and receiver).
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } seq_state_e;

  localparam int unsigned SYNC_W = 4;
  localparam logic [SYNC_W-1:0] SYNC_1101 = 4'b1101;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_tx_1101_piso_shift.sv
// Parallel-load shift register presenting its MSB; shifts left, zero-filling.
module piso_shift #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_msb
);

  logic [DATA_W-1:0] r_sreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sreg <= '0;
    end else if (i_load) begin
      r_sreg <= i_data;
    end else if (i_shift) begin
      r_sreg <= r_sreg << 1;
    end
  end

  assign o_msb = r_sreg[DATA_W-1];

endmodule

// File: rtl/seq_tx_1101.sv
// Frame transmitter: sync marker, payload MSB-first, then a forced-zero gap.
module seq_tx_1101
  import seq_pkg::*;
#(
  parameter int unsigned          DATA_W   = 8,
  parameter logic [SYNC_W-1:0]    SYNC     = SYNC_1101,
  parameter int unsigned          GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W      = $clog2(max3(DATA_W, SYNC_W, GAP_BITS));
  localparam int unsigned SYNC_IDX_W = $clog2(SYNC_W);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_BITS == 0) ? 0 : GAP_BITS - 1);

  seq_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_done;

  logic             w_load;
  logic             w_shift;
  logic             w_msb;
  logic [CNT_W-1:0] w_cnt_dec;

  assign in_ready  = (r_state == ST_IDLE) & ~rst;
  assign w_load    = in_valid & in_ready;
  assign w_cnt_dec = r_cnt - CNT_W'(1);
  // The register advances whenever its MSB is moved onto out.
  assign w_shift   = ((r_state == ST_SYNC) && (r_cnt == '0)) ||
                     ((r_state == ST_DATA) && (r_cnt != '0));

  piso_shift #(.DATA_W(DATA_W)) u_piso (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (in_data),
    .o_msb   (w_msb)
  );

  // r_cnt indexes the bit currently on out; outputs are loaded with the next bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_state     <= ST_SYNC;
            r_cnt       <= SYNC_LAST;
            r_out       <= SYNC[SYNC_W-1];
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_SYNC: begin
          if (r_cnt == '0) begin
            r_state <= ST_DATA;
            r_cnt   <= DATA_LAST;
            r_out   <= w_msb;
            r_done  <= (DATA_LAST == '0);
          end else begin
            r_cnt <= w_cnt_dec;
            r_out <= SYNC[w_cnt_dec[SYNC_IDX_W-1:0]];
          end
        end
        ST_DATA: begin
          if (r_cnt != '0) begin
            r_cnt  <= w_cnt_dec;
            r_out  <= w_msb;
            r_done <= (w_cnt_dec == '0);
          end else begin
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            if (GAP_BITS == 0) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_GAP;
              r_cnt   <= GAP_LAST;
            end
          end
        end
        ST_GAP: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= w_cnt_dec;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_seq_tx_1101.sv
// Scoreboard bench for seq_tx_1101: default build plus a GAP_BITS = 0 build.
module tb_seq_tx_1101;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, out, out_valid, busy, done;

  logic       in_valid0 = 1'b0;
  logic [7:0] in_data0 = 8'h00;
  logic       in_ready0, out0, out_valid0, busy0, done0;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] sbq[$];
  logic [1:0] e;
  int         run = 0;
  int         hits = 0;
  logic [3:0] hist = 4'h0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  int         hs_cyc = 0;

  seq_tx_1101 #(.DATA_W(8), .GAP_BITS(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .busy(busy), .done(done)
  );

  seq_tx_1101 #(.DATA_W(8), .GAP_BITS(0)) dut_g0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_data(in_data0),
    .in_ready(in_ready0), .out(out0), .out_valid(out_valid0), .busy(busy0), .done(done0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {out, done} for bit i of a frame carrying payload w.
  function automatic logic [1:0] fbit(input logic [7:0] w, input int i);
    logic [3:0] s;
    s = 4'b1101;
    if (i < 4) return {s[2'(3 - i)], 1'b0};
    return {w[3'(11 - i)], 1'(i == 11)};
  endfunction

  task automatic push_frame(input logic [7:0] w);
    for (int i = 0; i < 12; i++) sbq.push_back(fbit(w, i));
  endtask

  // Offer w; returns #1 after the accepting edge. hold keeps in_valid high.
  task automatic send(input logic [7:0] w, input bit hold);
    int t;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("hs_timeout", 32'(0), 32'(1));
      in_valid = 1'b0;
      return;
    end
    hs_cyc = cyc;
    @(posedge clk);
    push_frame(w);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((busy || sbq.size() != 0) && t < 200);
    if (t >= 200) check("idle_timeout", 32'(0), 32'(1));
  endtask

  // Output monitor: frame bits against the scoreboard, idle cycles against zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        run = 0;
      end else if (out_valid) begin
        run++;
        if (sbq.size() == 0) begin
          check("sb_empty", 32'(1), 32'(0));
        end else begin
          e = sbq.pop_front();
          check("out_bit", 32'(out), 32'(e[1]));
          check("done_bit", 32'(done), 32'(e[0]));
        end
      end else begin
        if (run != 0) begin
          check("run_len", 32'(run), 32'(12));
          run = 0;
        end
        check("idle_out", 32'(out), 32'(0));
        check("idle_done", 32'(done), 32'(0));
      end
    end
  end

  // Loopback model of a non-overlapping 1101 detector on the serial line.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      hist = {hist[2:0], out};
      if (hist == 4'b1101) begin
        hits++;
        hist = 4'h0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1;
    int h0;
    int cur;
    int ks[3];
    int t;

    #2 rst = 1'b1;
    #1;
    check("rst_out", 32'(out), 32'(0));
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_ready", 32'(in_ready), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(in_ready), 32'(1));
    check("rel_busy", 32'(busy), 32'(0));

    // Single frame, then explicit gap and return to idle.
    send(8'hA5, 1'b0);
    repeat (12) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      check("gap_valid", 32'(out_valid), 32'(0));
      check("gap_out", 32'(out), 32'(0));
      check("gap_busy", 32'(busy), 32'(1));
      check("gap_ready", 32'(in_ready), 32'(0));
    end
    @(negedge clk);
    check("post_ready", 32'(in_ready), 32'(1));
    check("post_busy", 32'(busy), 32'(0));
    check("a5_sb_drained", 32'(sbq.size()), 32'(0));

    // Back-to-back with in_valid held; in_data changes mid-frame are ignored.
    send(8'hFF, 1'b1);
    c1 = hs_cyc;
    #1 in_data = 8'h00;
    send(8'h00, 1'b1);
    check("b2b_period", 32'(hs_cyc - c1), 32'(15));
    in_valid = 1'b0;
    wait_idle();

    // Payload containing the marker goes out unescaped.
    h0 = hits;
    send(8'hDD, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);
    check("det_hits", 32'(hits - h0), 32'(3));

    // Asynchronous reset on the 5th payload bit.
    send(8'h3C, 1'b0);
    repeat (8) @(posedge clk);
    #2;
    check("pre_rst_valid", 32'(out_valid), 32'(1));
    rst = 1'b1;
    #1;
    sbq.delete();
    check("arst_out", 32'(out), 32'(0));
    check("arst_valid", 32'(out_valid), 32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_done", 32'(done), 32'(0));
    check("arst_ready", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("arst_rel_ready", 32'(in_ready), 32'(1));
    send(8'h96, 1'b0);
    wait_idle();

    // in_valid pulses during SYNC, DATA and GAP are not accepted.
    send(8'h5A, 1'b0);
    ks[0] = 1; ks[1] = 6; ks[2] = 12;
    cur = 0;
    for (int j = 0; j < 3; j++) begin
      repeat (ks[j] - cur) @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 8'hFF;
      @(negedge clk);
      check("ign_ready", 32'(in_ready), 32'(0));
      @(posedge clk);
      #1 in_valid = 1'b0;
      cur = ks[j] + 1;
    end
    wait_idle();
    repeat (5) @(negedge clk);
    check("ign_busy", 32'(busy), 32'(0));
    check("ign_sb_drained", 32'(sbq.size()), 32'(0));

    // GAP_BITS = 0 build: next word accepted right after done.
    @(negedge clk);
    in_valid0 = 1'b1;
    in_data0  = 8'hC3;
    t = 0;
    while (!in_ready0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("g0_ready", 32'(in_ready0), 32'(1));
    @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("g0_valid", 32'(out_valid0), 32'(1));
      check("g0_out", 32'(out0), 32'(fbit(8'hC3, i) >> 1));
      check("g0_done", 32'(done0), 32'(fbit(8'hC3, i) & 2'b01));
    end
    @(negedge clk);
    check("g0_idle_ready", 32'(in_ready0), 32'(1));
    check("g0_idle_valid", 32'(out_valid0), 32'(0));
    check("g0_idle_busy", 32'(busy0), 32'(0));
    @(posedge clk);
    #1 in_valid0 = 1'b0;
    @(negedge clk);
    check("g0_next_busy", 32'(busy0), 32'(1));
    check("g0_next_out", 32'(out0), 32'(1));
    repeat (14) @(negedge clk);
    check("g0_end_busy", 32'(busy0), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
